branch_predictor_ctrl: RTL
==========================

// Module: branch_predictor_ctrl
// PURPOSE
//  Sequencer and port arbiter for the single-ported 2-bit-counter predictor table. Serves lookups from IF
//  and training updates from EX over the one table port, giving EX priority.
//  Holds in-flight predictions in order and flags mispredictions on resolve.
//  Owns predictor initialisation and keeps miss and resolve counters.
// PARAMETERS
//  AW        3   predictor index width (table has 2**AW entries)
//  DEPTH     4   in-flight prediction queue entries (power of 2, >=2)
//  INIT_CYC  2   cycles PRED_INIT is held high after reset release
//  FLUSH_CYC 2   cycles lookups are blocked after a mispredict
// PORTS
//  CLOCK           in   1                 system clock, rising edge
//  RESET           in   1                 asynchronous, active-low reset
//  LOOKUP_REQ      in   1                 IF requests a prediction for LOOKUP_ADDR
//  LOOKUP_ADDR     in   AW                predictor index of fetched branch
//  LOOKUP_GNT      out  1                 comb: request accepted this cycle
//  LOOKUP_VALID    out  1                 reg: prediction for the cycle-t grant is valid at t+1
//  LOOKUP_TAKEN    out  1                 reg: predicted direction, qualified by LOOKUP_VALID
//  RESOLVE_VALID   in   1                 EX resolves oldest in-flight branch
//  RESOLVE_OUTCOME in   1                 actual direction (1=taken)
//  MISPREDICT      out  1                 reg pulse: resolved direction differed from prediction
//  REDIRECT_TAKEN  out  1                 reg: correct direction, qualified by MISPREDICT
//  PRED_INIT       out  1                 predictor table init strobe
//  PRED_ADDR       out  AW                predictor port index
//  PRED_UPDATE     out  1                 predictor trains PRED_ADDR with PRED_OUTCOME at the edge
//  PRED_OUTCOME    out  1                 training outcome
//  PRED_TAKEN      in   1                 predictor comb read of PRED_ADDR
//  OCCUPANCY       out  log2(DEPTH)+1     in-flight entries
//  MISSES          out  16                saturating mispredict count
//  RESOLVED        out  16                saturating resolve count
//  PROTO_ERR       out  1                 reg pulse: resolve with empty queue
// BEHAVIOUR
//  Reset (RESET=0, async):
//   - state=INIT, queue emptied, counters=0.
//   - All reg outputs 0, except PRED_INIT=1.
//  FSM:
//   - INIT: PRED_INIT=1 for INIT_CYC cycles after reset release, then go to RUN. No grants; resolves ignored.
//   - RUN: normal operation.
//   - FLUSH: entered on mispredict; queue already cleared; no grants for FLUSH_CYC cycles, then go to RUN.
//     Resolves in FLUSH raise PROTO_ERR (queue empty).
//  Port arbitration (comb):
//   - Resolve with non-empty queue: PRED_ADDR=head addr, PRED_UPDATE=1, PRED_OUTCOME=RESOLVE_OUTCOME;
//     LOOKUP_GNT=0 that cycle.
//   - Otherwise: PRED_ADDR=LOOKUP_ADDR, PRED_UPDATE=0.
//     LOOKUP_GNT = LOOKUP_REQ & RUN & (OCCUPANCY<DEPTH).
//  Grant at cycle t: push {LOOKUP_ADDR, PRED_TAKEN} at the edge; LOOKUP_VALID=1, LOOKUP_TAKEN=PRED_TAKEN at t+1.
//  Resolve pops head. An entry pushed at t is resolvable from t+1.
//   - RESOLVED+1 (saturate at 16'hFFFF).
//   - If head.taken != RESOLVE_OUTCOME:
//     - next cycle MISPREDICT=1, REDIRECT_TAKEN=RESOLVE_OUTCOME.
//     - MISSES+1 (saturating).
//     - whole queue cleared, state=FLUSH.
//  Simultaneous push and pop cannot occur (the resolve wins the port).
//  Queue pointers wrap modulo DEPTH; OCCUPANCY never exceeds DEPTH.
//  Reset asserted mid-FLUSH or mid-queue: everything returns to the reset values immediately.
// TESTING
//  Reset release -> PRED_INIT=1 for exactly 2 cycles; LOOKUP_GNT=0 until RUN even with LOOKUP_REQ=1.
//  Lookup addr 3'b001, PRED_TAKEN=0 -> GNT=1; next cycle LOOKUP_VALID=1, LOOKUP_TAKEN=0, OCCUPANCY=1.
//  Resolve outcome 0 on that entry -> PRED_UPDATE=1, PRED_ADDR=001, MISPREDICT stays 0, RESOLVED=1.
//  4 lookups with no resolve -> 5th REQ gets GNT=0. Then REQ+RESOLVE in the same cycle -> GNT=0, PRED_UPDATE=1.
//  Two in flight; head predicted 0, resolved 1 -> MISPREDICT pulse, REDIRECT_TAKEN=1, MISSES=1, OCCUPANCY=0,
//   no GNT for 2 cycles.
//  Resolve on empty queue -> PROTO_ERR 1-cycle pulse, no PRED_UPDATE, counters unchanged.

Source files
------------

// File: rtl/branch_predictor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_ctrl
// Purpose  : Port arbiter and sequencer for a single-ported 2-bit predictor
//            table: IF lookups, EX training (priority), in-order in-flight
//            tracking, mispredict flush, init strobe and event counters.
// Revision : 1.0
// ============================================================================
module branch_predictor_ctrl #(
    parameter int AW        = 3,
    parameter int DEPTH     = 4,
    parameter int INIT_CYC  = 2,
    parameter int FLUSH_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lookup_req,
    input  logic [AW-1:0]            lookup_addr,
    output logic                     lookup_gnt,
    output logic                     lookup_valid,
    output logic                     lookup_taken,
    input  logic                     resolve_valid,
    input  logic                     resolve_outcome,
    output logic                     mispredict,
    output logic                     redirect_taken,
    output logic                     pred_init,
    output logic [AW-1:0]            pred_addr,
    output logic                     pred_update,
    output logic                     pred_outcome,
    input  logic                     pred_taken,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              misses,
    output logic [15:0]              resolved,
    output logic                     proto_err
);

    localparam int PW   = $clog2(DEPTH);
    localparam int OW   = PW + 1;
    localparam int CMAX = (INIT_CYC > FLUSH_CYC) ? INIT_CYC : FLUSH_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [OW-1:0] C_FULL_CNT  = OW'(DEPTH);
    localparam logic [CW-1:0] C_INIT_LAST = CW'(INIT_CYC - 1);
    localparam logic [CW-1:0] C_FLSH_LAST = CW'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;

    logic [AW-1:0]       r_q_addr [DEPTH];
    logic [DEPTH-1:0]    r_q_taken;
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;

    logic                w_empty;
    logic                w_full;
    logic                w_active;
    logic                w_do_resolve;
    logic                w_proto;
    logic                w_miss;
    logic [AW-1:0]       w_head_addr;
    logic                w_head_taken;

    // The queue is empty whenever occupancy reads zero; the registered count
    // doubles as the OCCUPANCY output.
    assign w_empty      = (occupancy == '0);
    assign w_full       = (occupancy == C_FULL_CNT);
    assign w_active     = (r_state != ST_INIT);
    assign w_head_addr  = r_q_addr[r_rptr];
    assign w_head_taken = r_q_taken[r_rptr];

    assign w_do_resolve = resolve_valid & w_active & ~w_empty;
    assign w_proto      = resolve_valid & w_active &  w_empty;
    assign w_miss       = w_do_resolve & (w_head_taken != resolve_outcome);

    // Training owns the table port whenever it needs it; lookups yield.
    assign lookup_gnt   = lookup_req & (r_state == ST_RUN) & ~w_full & ~w_do_resolve;
    assign pred_addr    = w_do_resolve ? w_head_addr : lookup_addr;
    assign pred_update  = w_do_resolve;
    assign pred_outcome = resolve_outcome;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_INIT;
            r_cnt          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_addr[i] <= '0;
            end
            r_q_taken      <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            occupancy      <= '0;
            misses         <= '0;
            resolved       <= '0;
            lookup_valid   <= 1'b0;
            lookup_taken   <= 1'b0;
            mispredict     <= 1'b0;
            redirect_taken <= 1'b0;
            proto_err      <= 1'b0;
            pred_init      <= 1'b1;
        end else begin
            lookup_valid   <= lookup_gnt;
            lookup_taken   <= lookup_gnt & pred_taken;
            mispredict     <= w_miss;
            redirect_taken <= w_miss & resolve_outcome;
            proto_err      <= w_proto;

            if (lookup_gnt) begin
                r_q_addr[r_wptr]  <= lookup_addr;
                r_q_taken[r_wptr] <= pred_taken;
                r_wptr            <= r_wptr + PW'(1);
                occupancy         <= occupancy + OW'(1);
            end

            if (w_do_resolve) begin
                if (resolved != 16'hFFFF) begin
                    resolved <= resolved + 16'd1;
                end
                if (w_miss) begin
                    if (misses != 16'hFFFF) begin
                        misses <= misses + 16'd1;
                    end
                    r_wptr    <= '0;
                    r_rptr    <= '0;
                    occupancy <= '0;
                end else begin
                    r_rptr    <= r_rptr + PW'(1);
                    occupancy <= occupancy - OW'(1);
                end
            end

            case (r_state)
                ST_INIT: begin
                    if (r_cnt == C_INIT_LAST) begin
                        r_state   <= ST_RUN;
                        r_cnt     <= '0;
                        pred_init <= 1'b0;
                    end else begin
                        r_cnt     <= r_cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (w_miss) begin
                        r_state <= ST_FLUSH;
                        r_cnt   <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == C_FLSH_LAST) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
